// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encoding, opcodes and control words.
// The PAUSE state exists only when SINGLE_STEP_EN is defined.
package multicycle_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_PCUP   = 4'd6,
    ST_HALTED = 4'd7,
    ST_ERR    = 4'd8
`ifdef SINGLE_STEP_EN
    , ST_PAUSE = 4'd9
`endif
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } opcode_t;

  // Bit positions inside the control vector
  localparam int SIG_REGDST   = 7;
  localparam int SIG_REGWRITE = 6;
  localparam int SIG_ALUSRC   = 5;
  localparam int SIG_JMP      = 4;
  localparam int SIG_MEMREAD  = 3;
  localparam int SIG_MEMWRITE = 2;
  localparam int SIG_MEMTOREG = 1;
  localparam int SIG_ALUOP    = 0;

  localparam logic [7:0] CTRL_ADD = 8'hC1;  // REGDST, REGWRITE, ALUOP
  localparam logic [7:0] CTRL_LW  = 8'h6A;  // REGWRITE, ALUSRC, MEMREAD, MEMTOREG
  localparam logic [7:0] CTRL_SW  = 8'h24;  // ALUSRC, MEMWRITE
  localparam logic [7:0] CTRL_J   = 8'h10;  // JMP

  function automatic logic [7:0] ctrl_word(input opcode_t op);
    logic [7:0] w;
    case (op)
      OP_ADD:  w = CTRL_ADD;
      OP_LW:   w = CTRL_LW;
      OP_SW:   w = CTRL_SW;
      default: w = CTRL_J;
    endcase
    return w;
  endfunction

  function automatic logic op_is_mem(input opcode_t op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_step_edge_sync.sv
// Step-button synchroniser with rising-edge detect; only built when SINGLE_STEP_EN is defined.
`ifdef SINGLE_STEP_EN
module step_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic step_async,
  output logic step_rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= step_async;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign step_rise = sync2_reg & ~prev_reg;

endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch via req/ack, then DECODE/EXEC/MEM/WB/PCUP with registered strobes.
// Define SINGLE_STEP_EN to add the STEP input and a PAUSE state after every retired instruction.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int MEM_LAT       = 2,
  parameter int FETCH_TIMEOUT = 15,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             instr_req,
  input  logic             instr_ack,
  input  logic [7:0]       instr,
  input  logic             halt,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [7:0]       ir,
  output logic [7:0]       signal,
  output logic             reg_we,
  output logic             mem_re,
  output logic             mem_we,
  output logic             pc_en,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  // One down-counter serves both the fetch timeout and the memory hold time
  localparam logic [7:0] TIMEOUT_LD = 8'(FETCH_TIMEOUT - 1);
  localparam logic [7:0] MEM_LD     = 8'(MEM_LAT - 1);

  state_t     state_reg;
  logic [7:0] cnt_reg;
  opcode_t    op;

  assign op = opcode_t'(ir[7:6]);

`ifdef SINGLE_STEP_EN
  logic step_rise;

  step_edge_sync u_step_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .step_async(step),
    .step_rise (step_rise)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      ir        <= '0;
      signal    <= '0;
      instr_req <= 1'b0;
      reg_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      pc_en     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      reg_we <= 1'b0;
      pc_en  <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_HALTED: begin
          if (halt) begin
            state_reg <= ST_HALTED;
          end else begin
            state_reg <= ST_FETCH;
            instr_req <= 1'b1;
            busy      <= 1'b1;
            cnt_reg   <= TIMEOUT_LD;
          end
        end

        ST_FETCH: begin
          // An ACK in the last allowed cycle still wins over the timeout
          if (instr_ack) begin
            state_reg <= ST_DECODE;
            instr_req <= 1'b0;
            ir        <= instr;
            signal    <= ctrl_word(opcode_t'(instr[7:6]));
          end else if (cnt_reg == '0) begin
            state_reg <= ST_ERR;
            instr_req <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_DECODE: begin
          if (op == OP_J) begin
            state_reg <= ST_PCUP;
            pc_en     <= 1'b1;
            retired   <= retired + 1'b1;
          end else begin
            state_reg <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          if (op_is_mem(op)) begin
            state_reg <= ST_MEM;
            cnt_reg   <= MEM_LD;
            mem_re    <= (op == OP_LW);
            mem_we    <= (op == OP_SW);
          end else begin
            state_reg <= ST_WB;
            reg_we    <= 1'b1;
          end
        end

        ST_MEM: begin
          if (cnt_reg == '0) begin
            mem_re <= 1'b0;
            mem_we <= 1'b0;
            if (op == OP_LW) begin
              state_reg <= ST_WB;
              reg_we    <= 1'b1;
            end else begin
              state_reg <= ST_PCUP;
              pc_en     <= 1'b1;
              retired   <= retired + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end

        ST_WB: begin
          state_reg <= ST_PCUP;
          pc_en     <= 1'b1;
          retired   <= retired + 1'b1;
        end

        ST_PCUP: begin
          signal <= '0;
          if (halt) begin
            state_reg <= ST_HALTED;
            busy      <= 1'b0;
          end else begin
`ifdef SINGLE_STEP_EN
            state_reg <= ST_PAUSE;
            busy      <= 1'b0;
`else
            state_reg <= ST_FETCH;
            instr_req <= 1'b1;
            cnt_reg   <= TIMEOUT_LD;
`endif
          end
        end

`ifdef SINGLE_STEP_EN
        ST_PAUSE: begin
          if (halt) begin
            state_reg <= ST_HALTED;
          end else if (step_rise) begin
            state_reg <= ST_FETCH;
            instr_req <= 1'b1;
            busy      <= 1'b1;
            cnt_reg   <= TIMEOUT_LD;
          end
        end
`endif

        ST_ERR: begin
          state_reg <= ST_ERR;
        end

        default: begin
          // Unreachable encodings park in the error state
          state_reg <= ST_ERR;
          instr_req <= 1'b0;
          signal    <= '0;
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
          busy      <= 1'b0;
          err       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed cases plus random instructions
// compared cycle by cycle against a latency-based reference model.
module tb_multicycle_sequencer;

  localparam int MEM_LAT       = 2;
  localparam int FETCH_TIMEOUT = 15;
  localparam int CNT_W         = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             instr_req;
  logic             instr_ack;
  logic [7:0]       instr;
  logic             halt;
`ifdef SINGLE_STEP_EN
  logic             step = 1'b0;
`endif
  logic [7:0]       ir;
  logic [7:0]       signal;
  logic             reg_we;
  logic             mem_re;
  logic             mem_we;
  logic             pc_en;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] retired;

  int         total_cnt = 0;
  int         pass_cnt  = 0;
  int         fail_cnt  = 0;
  int         txn_cnt   = 0;
  logic [7:0] exp_ret   = 8'd0;

  multicycle_sequencer #(
    .MEM_LAT      (MEM_LAT),
    .FETCH_TIMEOUT(FETCH_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr_req(instr_req),
    .instr_ack(instr_ack),
    .instr    (instr),
    .halt     (halt),
`ifdef SINGLE_STEP_EN
    .step     (step),
`endif
    .ir       (ir),
    .signal   (signal),
    .reg_we   (reg_we),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .pc_en    (pc_en),
    .busy     (busy),
    .err      (err),
    .retired  (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {signal, reg_we, mem_re, mem_we, pc_en, busy, instr_req}
  function automatic logic [13:0] dut_vec();
    return {signal, reg_we, mem_re, mem_we, pc_en, busy, instr_req};
  endfunction

  function automatic logic [7:0] word_of(input logic [1:0] op);
    case (op)
      2'd0:    return 8'hC1;
      2'd1:    return 8'h6A;
      2'd2:    return 8'h24;
      default: return 8'h10;
    endcase
  endfunction

  // Cycles after the fetch cycle: total latency minus the single fetch cycle
  function automatic int post_cycles(input logic [1:0] op);
    case (op)
      2'd0:    return 4;
      2'd1:    return 4 + MEM_LAT;
      2'd2:    return 3 + MEM_LAT;
      default: return 2;
    endcase
  endfunction

  function automatic logic [13:0] exp_post(input logic [1:0] op, input int j, input int n);
    logic writes, is_mem, in_mem;
    writes = (op == 2'd0) || (op == 2'd1);
    is_mem = (op == 2'd1) || (op == 2'd2);
    in_mem = is_mem && (j >= 3) && (j <= 2 + MEM_LAT);
    return {word_of(op), writes && (j == n - 1), in_mem && (op == 2'd1),
            in_mem && (op == 2'd2), j == n, 1'b1, 1'b0};
  endfunction

  // Starts at a negedge where FETCH is visible; ends at the negedge after PCUP (or after abort)
  task automatic run_instr(input logic [7:0] iw, input int d, input int halt_j, input int abort_j);
    logic [1:0] op;
    int n;
    op = iw[7:6];
    n  = post_cycles(op);
    for (int k = 0; k <= d; k++) begin
      check("fetch_vec", 32'(dut_vec()), {18'd0, 8'h00, 6'b000011});
      instr_ack = (k == d);
      instr     = (k == d) ? iw : 8'($urandom);
      @(negedge clk);
    end
    for (int j = 1; j <= n; j++) begin
      check($sformatf("post_vec_op%0d_j%0d", op, j), 32'(dut_vec()), 32'(exp_post(op, j, n)));
      if (j == 1) check("ir_latch", 32'(ir), 32'(iw));
      if (j == n) begin
        exp_ret = exp_ret + 8'd1;
        check("retired", 32'(retired), 32'(exp_ret));
      end
      if (j == abort_j) begin
        rst_n = 1'b0;
        #1;
        check("abort_zero", {err, instr_req, busy, pc_en, mem_we, mem_re, reg_we, signal, ir, retired}, 32'd0);
        exp_ret = 8'd0;
        $display("txn %0d op=%0d instr=%h aborted at post-cycle %0d", txn_cnt, op, iw, j);
        txn_cnt++;
        return;
      end
      if (halt_j > 0 && j >= halt_j) halt = 1'b1;
      instr_ack = 1'($urandom);
      instr     = 8'($urandom);
      @(negedge clk);
    end
    instr_ack = 1'b0;
    $display("txn %0d op=%0d instr=%h ack_delay=%0d retired=%0d", txn_cnt, op, iw, d, retired);
    txn_cnt++;
  endtask

  initial begin
    logic [7:0] iw;
    rst_n = 1'b0;
    halt = 1'b0;
    instr_ack = 1'b0;
    instr = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {err, instr_req, busy, pc_en, mem_we, mem_re, reg_we, signal, ir, retired}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_instr(8'h06, 0, 0, 0);   // ADD
    run_instr(8'h41, 0, 0, 0);   // LW
    run_instr(8'hC3, 0, 0, 0);   // J
    run_instr(8'h9D, 1, 0, 0);   // SW with one wait cycle

    for (int t = 0; t < 20; t++) begin
      iw = 8'($urandom);
      run_instr(iw, int'($urandom_range(0, 5)), 0, 0);
    end

    // HALT raised in LW's first MEM cycle: instruction completes, then HALTED
    run_instr(8'h52, 0, 3, 0);
    for (int k = 0; k < 3; k++) begin
      check("halted_vec", 32'(dut_vec()), 32'd0);
      instr_ack = 1'($urandom);
      @(negedge clk);
    end
    instr_ack = 1'b0;
    halt = 1'b0;
    @(negedge clk);

    // ACK on the last allowed fetch cycle is accepted
    run_instr(8'h07, FETCH_TIMEOUT - 1, 0, 0);

    // Fetch timeout
    for (int k = 0; k < FETCH_TIMEOUT; k++) begin
      check("timeout_wait", {31'd0, instr_req}, 32'd1);
      @(negedge clk);
    end
    check("err_set", {err, busy, instr_req}, 32'b100);
    for (int k = 0; k < 3; k++) begin
      instr_ack = 1'b1;
      instr = 8'h06;
      @(negedge clk);
      check("err_sticky", {err, busy, instr_req, signal}, {21'd0, 3'b100, 8'h00});
    end
    instr_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    check("err_cleared", {31'd0, err}, 32'd0);
    exp_ret = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during SW MEM
    run_instr(8'hA5, 0, 0, 3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 256 retirements from reset wrap the counter
    for (int t = 0; t < 256; t++) begin
      iw = 8'($urandom);
      iw[7:6] = 2'b11;
      run_instr(iw, int'($urandom_range(0, 2)), 0, 0);
    end
    check("retired_wrap", 32'(retired), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
